// File: rtl/sdram_arbit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sdram_arbit_if                                                 |
// | Purpose  : Sequencer-side handshakes and SDRAM pad bus of the arbiter.    |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface sdram_arbit_if #(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2
);
  logic              flag_init_end;
  logic [3:0]        init_cmd;
  logic [ADDR_W-1:0] init_addr;
  logic              ref_req;
  logic              ref_en;
  logic              flag_ref_end;
  logic [3:0]        aref_cmd;
  logic [ADDR_W-1:0] aref_addr;
  logic              wr_req;
  logic              wr_en;
  logic              flag_wr_end;
  logic [3:0]        wr_cmd;
  logic [ADDR_W-1:0] wr_addr;
  logic [BA_W-1:0]   wr_bank;
  logic              rd_req;
  logic              rd_en;
  logic              flag_rd_end;
  logic [3:0]        rd_cmd;
  logic [ADDR_W-1:0] rd_addr;
  logic [BA_W-1:0]   rd_bank;
  logic              sdram_cke;
  logic              sdram_cs_n;
  logic              sdram_ras_n;
  logic              sdram_cas_n;
  logic              sdram_we_n;
  logic [ADDR_W-1:0] sdram_addr;
  logic [BA_W-1:0]   sdram_bank;
  logic [2:0]        arb_state;

  modport slave (
    input  flag_init_end, init_cmd, init_addr,
    input  ref_req, flag_ref_end, aref_cmd, aref_addr,
    input  wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank,
    input  rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
    output ref_en, wr_en, rd_en,
    output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    output sdram_addr, sdram_bank, arb_state
  );

  modport master (
    output flag_init_end, init_cmd, init_addr,
    output ref_req, flag_ref_end, aref_cmd, aref_addr,
    output wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank,
    output rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
    input  ref_en, wr_en, rd_en,
    input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    input  sdram_addr, sdram_bank, arb_state
  );
endinterface
`default_nettype wire

// File: rtl/sdram_arbit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sdram_arbit                                                    |
// | Purpose  : Grants the SDRAM command bus to init/refresh/write/read.       |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module sdram_arbit #(
  parameter int         ADDR_W  = 13,
  parameter int         BA_W    = 2,
  parameter logic [3:0] CMD_NOP = 4'b0111
) (
  input  wire             sclk,
  input  wire             s_rst_n,
  sdram_arbit_if.slave    bus
);

  localparam logic [2:0] c_s_init  = 3'd0;
  localparam logic [2:0] c_s_arbit = 3'd1;
  localparam logic [2:0] c_s_aref  = 3'd2;
  localparam logic [2:0] c_s_write = 3'd3;
  localparam logic [2:0] c_s_read  = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic              r_last_wr;
  logic              w_gnt_ref;
  logic              w_gnt_wr;
  logic              w_gnt_rd;
  logic [3:0]        w_cmd;
  logic [ADDR_W-1:0] w_addr;
  logic [BA_W-1:0]   w_bank;

  // Refresh wins; contested write/read alternates on the last data grant.
  always_comb begin
    w_gnt_ref = 1'b0;
    w_gnt_wr  = 1'b0;
    w_gnt_rd  = 1'b0;
    if (r_state == c_s_arbit) begin
      if (bus.ref_req) begin
        w_gnt_ref = 1'b1;
      end else if (bus.wr_req && bus.rd_req) begin
        w_gnt_rd = r_last_wr;
        w_gnt_wr = ~r_last_wr;
      end else if (bus.wr_req) begin
        w_gnt_wr = 1'b1;
      end else if (bus.rd_req) begin
        w_gnt_rd = 1'b1;
      end
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state   <= c_s_init;
      r_last_wr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt_wr) begin
        r_last_wr <= 1'b1;
      end else if (w_gnt_rd) begin
        r_last_wr <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_s_init:  if (bus.flag_init_end) w_state_nxt = c_s_arbit;
      c_s_arbit: begin
        if (w_gnt_ref)     w_state_nxt = c_s_aref;
        else if (w_gnt_wr) w_state_nxt = c_s_write;
        else if (w_gnt_rd) w_state_nxt = c_s_read;
      end
      c_s_aref:  if (bus.flag_ref_end) w_state_nxt = c_s_arbit;
      c_s_write: if (bus.flag_wr_end)  w_state_nxt = c_s_arbit;
      c_s_read:  if (bus.flag_rd_end)  w_state_nxt = c_s_arbit;
      default:   w_state_nxt = c_s_init;
    endcase
  end

  // Pad mux keyed only on the registered owner: no added latency.
  always_comb begin
    w_cmd  = CMD_NOP;
    w_addr = '0;
    w_bank = '0;
    case (r_state)
      c_s_init: begin
        w_cmd  = bus.init_cmd;
        w_addr = bus.init_addr;
      end
      c_s_aref: begin
        w_cmd  = bus.aref_cmd;
        w_addr = bus.aref_addr;
      end
      c_s_write: begin
        w_cmd  = bus.wr_cmd;
        w_addr = bus.wr_addr;
        w_bank = bus.wr_bank;
      end
      c_s_read: begin
        w_cmd  = bus.rd_cmd;
        w_addr = bus.rd_addr;
        w_bank = bus.rd_bank;
      end
      default: begin
        w_cmd  = CMD_NOP;
        w_addr = '0;
        w_bank = '0;
      end
    endcase
  end

  assign bus.ref_en      = w_gnt_ref;
  assign bus.wr_en       = w_gnt_wr;
  assign bus.rd_en       = w_gnt_rd;
  assign bus.sdram_cke   = 1'b1;
  assign bus.sdram_cs_n  = w_cmd[3];
  assign bus.sdram_ras_n = w_cmd[2];
  assign bus.sdram_cas_n = w_cmd[1];
  assign bus.sdram_we_n  = w_cmd[0];
  assign bus.sdram_addr  = w_addr;
  assign bus.sdram_bank  = w_bank;
  assign bus.arb_state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sdram_arbit                                                 |
// | Purpose  : Directed bench with an ownership model checked every cycle.   |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_sdram_arbit;

  logic sclk;
  logic s_rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_on = 1'b0;

  sdram_arbit_if #(.ADDR_W(13), .BA_W(2)) bus ();

  sdram_arbit #(.ADDR_W(13), .BA_W(2), .CMD_NOP(4'b0111)) dut (
    .sclk    (sclk),
    .s_rst_n (s_rst_n),
    .bus     (bus.slave)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Model: owner 0=init 1=idle 2=refresh 3=write 4=read, plus "last data grant was a write".
  int m_state   = 0;
  bit m_last_wr = 1'b0;

  function automatic bit req_of(input int who);
    return (who == 3) ? bus.wr_req : bus.rd_req;
  endfunction

  function automatic int exp_grant();
    int first;
    int second;
    if (m_state != 1) return 0;
    if (bus.ref_req) return 2;
    first  = m_last_wr ? 4 : 3;
    second = m_last_wr ? 3 : 4;
    if (req_of(first))  return first;
    if (req_of(second)) return second;
    return 0;
  endfunction

  function automatic logic [25:0] exp_vec();
    int          g;
    logic [3:0]  c;
    logic [12:0] a;
    logic [1:0]  b;
    g = exp_grant();
    c = 4'b0111; a = 13'h0; b = 2'b00;
    if (m_state == 0) begin c = bus.init_cmd; a = bus.init_addr; end
    if (m_state == 2) begin c = bus.aref_cmd; a = bus.aref_addr; end
    if (m_state == 3) begin c = bus.wr_cmd;   a = bus.wr_addr; b = bus.wr_bank; end
    if (m_state == 4) begin c = bus.rd_cmd;   a = bus.rd_addr; b = bus.rd_bank; end
    return {3'(m_state), g == 2, g == 3, g == 4, c, a, b, 1'b1};
  endfunction

  always @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      m_state   <= 0;
      m_last_wr <= 1'b0;
    end else begin
      case (m_state)
        0: if (bus.flag_init_end) m_state <= 1;
        1: begin
          case (exp_grant())
            2: m_state <= 2;
            3: begin m_state <= 3; m_last_wr <= 1'b1; end
            4: begin m_state <= 4; m_last_wr <= 1'b0; end
            default: ;
          endcase
        end
        2: if (bus.flag_ref_end) m_state <= 1;
        3: if (bus.flag_wr_end)  m_state <= 1;
        4: if (bus.flag_rd_end)  m_state <= 1;
        default: m_state <= 0;
      endcase
    end
  end

  function automatic logic [25:0] act_vec();
    return {bus.arb_state, bus.ref_en, bus.wr_en, bus.rd_en,
            bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n,
            bus.sdram_addr, bus.sdram_bank, bus.sdram_cke};
  endfunction

  always @(negedge sclk) begin
    if (chk_on) begin
      n_vec++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL cycle_cmp @%0t: got %h expected %h", $time, act_vec(), exp_vec());
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  function automatic logic [3:0] pins();
    return {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n};
  endfunction

  // Waits for a grant, keeps the burst two cycles, then pulses the owner's end flag.
  task automatic burst(output int who);
    int n;
    who = 0;
    n   = 0;
    while (who == 0 && n < 20) begin
      @(negedge sclk);
      if (bus.wr_en)       who = 1;
      else if (bus.rd_en)  who = 2;
      else if (bus.ref_en) who = 3;
      n++;
    end
    if (who == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL burst_grant: got no grant expected one within 20 cycles");
      return;
    end
    tick();
    @(negedge sclk);
    if (who == 2) chk("rd_bank", 32'(bus.sdram_bank), 32'h2);
    tick();
    if (who == 1) bus.flag_wr_end = 1'b1;
    if (who == 2) bus.flag_rd_end = 1'b1;
    if (who == 3) bus.flag_ref_end = 1'b1;
    tick();
    bus.flag_wr_end  = 1'b0;
    bus.flag_rd_end  = 1'b0;
    bus.flag_ref_end = 1'b0;
  endtask

  initial begin
    int who;
    int seq [4];
    int en_cnt;
    int n;
    s_rst_n           = 1'b0;
    bus.flag_init_end = 1'b0;
    bus.init_cmd      = 4'b0010;
    bus.init_addr     = 13'h400;
    bus.ref_req       = 1'b0;
    bus.flag_ref_end  = 1'b0;
    bus.aref_cmd      = 4'b0001;
    bus.aref_addr     = 13'h400;
    bus.wr_req        = 1'b0;
    bus.flag_wr_end   = 1'b0;
    bus.wr_cmd        = 4'b0100;
    bus.wr_addr       = 13'h0AB;
    bus.wr_bank       = 2'b01;
    bus.rd_req        = 1'b0;
    bus.flag_rd_end   = 1'b0;
    bus.rd_cmd        = 4'b0101;
    bus.rd_addr       = 13'h1C3;
    bus.rd_bank       = 2'b10;
    tick();
    chk_on = 1'b1;
    tick();
    s_rst_n = 1'b1;

    // Init passthrough while the init sequencer is still busy.
    repeat (10) tick();
    @(negedge sclk);
    chk("init_state", 32'(bus.arb_state), 32'h0);
    chk("init_pins", 32'(pins()), 32'h2);
    chk("init_addr", 32'(bus.sdram_addr), 32'h400);
    tick();
    bus.flag_init_end = 1'b1;
    tick();
    @(negedge sclk);
    chk("arbit_state", 32'(bus.arb_state), 32'h1);
    chk("arbit_nop", 32'(pins()), 32'h7);

    // Refresh beats a simultaneous write request.
    tick();
    bus.ref_req = 1'b1;
    bus.wr_req  = 1'b1;
    @(negedge sclk);
    chk("ref_first_en", 32'({bus.ref_en, bus.wr_en}), 32'h2);
    tick();
    bus.ref_req = 1'b0;
    @(negedge sclk);
    chk("aref_state", 32'(bus.arb_state), 32'h2);
    chk("aref_pins", 32'(pins()), 32'h1);
    tick();
    bus.flag_ref_end = 1'b1;
    tick();
    bus.flag_ref_end = 1'b0;
    @(negedge sclk);
    chk("wr_after_ref", 32'(bus.wr_en), 32'h1);

    // No preemption, foreign end flags ignored, refresh queued ahead of the next write.
    tick();
    bus.ref_req     = 1'b1;
    bus.flag_rd_end = 1'b1;
    tick();
    bus.flag_rd_end = 1'b0;
    @(negedge sclk);
    chk("write_hold", 32'(bus.arb_state), 32'h3);
    tick();
    bus.flag_wr_end = 1'b1;
    tick();
    bus.flag_wr_end = 1'b0;
    @(negedge sclk);
    chk("ref_before_wr", 32'({bus.ref_en, bus.wr_en}), 32'h2);
    tick();
    bus.ref_req = 1'b0;
    bus.wr_req  = 1'b0;
    tick();
    bus.flag_ref_end = 1'b1;
    tick();
    bus.flag_ref_end = 1'b0;

    // Lone read, then contested write/read alternation.
    bus.rd_req = 1'b1;
    burst(who);
    chk("lone_read", 32'(who), 32'h2);
    bus.wr_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      burst(who);
      seq[i] = who;
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    chk("alt_0", 32'(seq[0]), 32'h1);
    chk("alt_1", 32'(seq[1]), 32'h2);
    chk("alt_2", 32'(seq[2]), 32'h1);
    chk("alt_3", 32'(seq[3]), 32'h2);

    // Asynchronous reset in the middle of a read burst.
    tick();
    bus.rd_req = 1'b1;
    n = 0;
    while (!bus.rd_en && n < 10) begin
      @(negedge sclk);
      n++;
    end
    chk("rd_grant_seen", 32'(bus.rd_en), 32'h1);
    tick();
    bus.rd_req = 1'b0;
    @(negedge sclk);
    chk("read_state", 32'(bus.arb_state), 32'h4);
    #2;
    s_rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(bus.arb_state), 32'h0);
    chk("rst_rd_en", 32'(bus.rd_en), 32'h0);
    chk("rst_pins", 32'(pins()), 32'h2);
    chk("rst_addr", 32'(bus.sdram_addr), 32'h400);
    tick();
    tick();
    s_rst_n = 1'b1;
    tick();

    // Long idle stretch: no grants, steady NOP.
    en_cnt = 0;
    repeat (100) begin
      @(negedge sclk);
      if (bus.ref_en || bus.wr_en || bus.rd_en) en_cnt++;
    end
    chk("idle_enables", 32'(en_cnt), 32'h0);
    chk("idle_pins", 32'(pins()), 32'h7);
    chk("idle_addr", 32'(bus.sdram_addr), 32'h0);
    chk("idle_cke", 32'(bus.sdram_cke), 32'h1);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/sdram_arbit.md
Name: sdram_arbit

Overview:
Central SDRAM command arbiter. It shares the single SDRAM command/address bus between the init, auto-refresh, write and read sequencers. The block grants the bus to one sequencer at a time and drives the chip pins from the granted sequencer. It sits between the four sequencers and the SDRAM pads.

Parameters:
ADDR_W, 13, SDRAM address width
BA_W, 2, bank address width
CMD_NOP, 4'b0111, {cs_n,ras_n,cas_n,we_n} NOP encoding driven when no owner

Ports:
sclk  in  1  system clock
s_rst_n  in  1  async active-low reset
flag_init_end  in  1  init sequencer done (level, stays high)
init_cmd  in  4  init command
init_addr  in  ADDR_W  init address
ref_req  in  1  refresh request (level until ref_en)
ref_en  out  1  refresh grant pulse
flag_ref_end  in  1  refresh sequence done
aref_cmd  in  4  refresh command
aref_addr  in  ADDR_W  refresh address
wr_req  in  1  write request (level)
wr_en  out  1  write grant pulse
flag_wr_end  in  1  write burst done
wr_cmd  in  4  write command
wr_addr  in  ADDR_W  write address
wr_bank  in  BA_W  write bank
rd_req  in  1  read request (level)
rd_en  out  1  read grant pulse
flag_rd_end  in  1  read burst done
rd_cmd  in  4  read command
rd_addr  in  ADDR_W  read address
rd_bank  in  BA_W  read bank
sdram_cke  out  1  clock enable
sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins
sdram_addr  out  ADDR_W  address pins
sdram_bank  out  BA_W  bank pins
arb_state  out  3  current state (debug)

Behaviour:
- Reset s_rst_n, asynchronous, active-low; clock sclk. On reset: state=INIT, last_wr=0, all *_en=0. sdram_cke stays 1 (constant).
- States (one-hot or binary, arb_state encoding): INIT=0, ARBIT=1, AREF=2, WRITE=3, READ=4.
- INIT: pins follow init_cmd/init_addr, bank=0. Go to ARBIT on the edge where flag_init_end=1. Requests in INIT are ignored and not lost, because they are levels.
- ARBIT: pins=CMD_NOP, addr=0, bank=0. Grant is decided in this cycle:
  - ref_req has priority: ref_en=1, next state AREF.
  - Else wr_req and rd_req both high: grant write if last_wr=0, otherwise grant read (alternation).
  - Else wr_req alone: wr_en=1, next WRITE. rd_req alone: rd_en=1, next READ.
  - No request: stay in ARBIT.
- Enables are combinational from (state==ARBIT && grant). Each is high exactly one cycle, in the same cycle the state registers the new owner. At most one *_en is high in any cycle.
- last_wr is set to 1 when write is granted and cleared when read is granted. Refresh grants leave it unchanged.
- AREF/WRITE/READ: pins follow the owner's cmd/addr (and bank for WRITE/READ; bank=0 in AREF). Return to ARBIT on the edge where the owner's flag_*_end=1. Flags from non-owners are ignored.
- There is always at least one ARBIT (NOP) cycle between owners; no direct owner-to-owner transition.
- A refresh request arriving mid-burst waits for that burst's end flag. No preemption.
- Pin outputs are a combinational mux of registered state, adding zero latency. Command decode: {cs_n,ras_n,cas_n,we_n}=cmd[3:0].
- flag_init_end falling after INIT has no effect. Only reset returns the block to INIT.
- Reset asserted mid-burst: immediate return to INIT with NOP-free init passthrough. Sequencers are reset by the same s_rst_n.

Test Plan:
- Reset, init_cmd=4'b0010, addr=13'h400, flag_init_end=0 for 10 cycles -> pins = 0,0,1,0 and addr=13'h400 throughout; flag_init_end=1 -> arb_state=1 next cycle, pins=NOP.
- ARBIT, ref_req and wr_req both high -> ref_en=1 for 1 cycle, state=AREF. aref_cmd=4'b0001 appears on pins. flag_ref_end -> ARBIT, then wr_en=1 next cycle.
- wr_req and rd_req held high continuously -> grant order W,R,W,R (4 bursts), each separated by ≥1 NOP cycle; rd_bank=2'b10 visible during READ.
- During WRITE, assert ref_req plus spurious flag_rd_end -> stays WRITE; after flag_wr_end, ref_en fires before any further wr_en.
- Assert s_rst_n=0 mid-READ -> arb_state=0 and rd_en=0 immediately (asynchronously); pins follow init_cmd.
- Idle ARBIT 100 cycles with no requests -> no enables; pins constant NOP (4'b0111), addr=0.
